// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues one memory request at a time and buffers up to
// two {instr, pc} pairs for the decoder. Handles branch/jalr redirects with stale-response discard.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | issue a request at pc when the buffer has room
// WAIT  | one request outstanding, waiting for imem_rvalid
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] immext,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [1:0]  count, count_nxt;
  logic        rd_ptr, rd_ptr_nxt;
  logic        wr_idx;
  logic        push, pop, redir_eff;
  logic [31:0] redir_tgt;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];

  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign wr_idx      = rd_ptr ^ (count == 2'd1);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    imem_req    = 1'b0;
    push        = 1'b0;
    redir_eff   = redirect && ((pcsrc == 2'b01) || (pcsrc == 2'b10));
    redir_tgt   = (pcsrc == 2'b10) ? (alu_result & 32'hFFFF_FFFE)
                                   : (redirect_pc + immext);
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (count < 2'd2) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
          if (redir_eff) discard_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // a response that crosses a redirect (same cycle or earlier) is dropped
          state_nxt   = FETCH;
          discard_nxt = 1'b0;
          if (!discard && !redir_eff) begin
            push   = 1'b1;
            pc_nxt = pc + 32'd4;
          end
        end else if (redir_eff) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redir_eff) pc_nxt = redir_tgt;

    pop        = instr_valid && instr_ready;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    if (redir_eff) begin
      count_nxt = 2'd0;
    end else begin
      if (pop) rd_ptr_nxt = ~rd_ptr;
      if (push && !pop)      count_nxt = count + 2'd1;
      else if (pop && !push) count_nxt = count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      count   <= count_nxt;
      rd_ptr  <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_idx] <= imem_rdata;
      buf_pc[wr_idx]    <= pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: bench-side memory with configurable latency, a queue-based
// reference of the fetch stream, directed scenarios followed by random traffic.
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  pcsrc = 2'd0;
  logic [31:0] redirect_pc = 32'd0, immext = 32'd0, alu_result = 32'd0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
    .pcsrc(pcsrc), .redirect_pc(redirect_pc), .immext(immext), .alu_result(alu_result)
  );

  int vectors = 0, errs = 0, cyc = 0;

  logic        rst_v = 1'b1, rdy_v = 1'b0, redir_v = 1'b0, force_rv = 1'b0;
  logic [1:0]  pcsrc_v = 2'd0;
  logic [31:0] rpc_v = 32'd0, imm_v = 32'd0, alu_v = 32'd0;
  int          lat = 1;

  bit          mem_pend = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] issued[$];
  int          issued_cyc[$];
  bit          req_seen = 1'b0;

  bit          m_ok = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_out, m_disc, m_idle;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] iss(input int i);
    if (i < issued.size()) return issued[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int gap(input int i);
    if (i + 1 < issued_cyc.size()) return issued_cyc[i+1] - issued_cyc[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic exp_req;
    if (!m_ok) return;
    exp_req = !m_idle && !m_out && (m_q.size() < 2);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("instr_pc", instr_pc, m_q[0]);
      chk("instr", instr, mk(m_q[0]));
    end
  endtask

  task automatic model_update(input logic rv);
    logic eff, issue, push, pop;
    logic [31:0] tgt;
    if (rst_v) begin
      m_ok = 1'b1; m_pc = RPC; m_q.delete();
      m_out = 1'b0; m_disc = 1'b0; m_idle = 1'b1;
      return;
    end
    if (!m_ok) return;
    eff   = redir_v && (pcsrc_v == 2'b01 || pcsrc_v == 2'b10);
    tgt   = (pcsrc_v == 2'b10) ? {alu_v[31:1], 1'b0} : rpc_v + imm_v;
    issue = !m_idle && !m_out && (m_q.size() < 2);
    push  = 1'b0;
    if (m_out && rv) begin
      push   = !m_disc && !eff;
      m_out  = 1'b0;
      m_disc = 1'b0;
    end
    pop = (m_q.size() != 0) && rdy_v;
    if (eff) begin
      m_q.delete();
      m_pc = tgt;
      if (issue) begin
        m_out = 1'b1; m_disc = 1'b1;
      end else if (m_out) begin
        m_disc = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        vectors++;
        assert (m_q.size() < 2) else begin
          errs++;
          $error("FAIL fifo_overflow: depth %0d expected below 2", m_q.size());
        end
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (issue) m_out = 1'b1;
    end
    m_idle = 1'b0;
  endtask

  task automatic cycle();
    logic rv;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    model_check();
    rv = 1'b0;
    rd = $urandom;
    req_seen = 1'b0;
    if (mem_pend) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        rv = 1'b1; rd = mk(mem_addr); mem_pend = 1'b0;
      end
    end
    if (force_rv) rv = 1'b1;
    if (imem_req === 1'b1) begin
      req_seen = 1'b1;
      issued.push_back(imem_addr);
      issued_cyc.push_back(cyc);
      mem_pend = 1'b1; mem_wait = lat; mem_addr = imem_addr;
    end
    if (rst_v) mem_pend = 1'b0;
    rst = rst_v; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy_v;
    redirect = redir_v; pcsrc = pcsrc_v; redirect_pc = rpc_v; immext = imm_v; alu_result = alu_v;
    @(posedge clk);
    model_update(rv);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (req_seen) return;
    end
    chk(tag, {31'd0, req_seen}, 32'd1);
  endtask

  initial begin
    int n0;
    rst_v = 1'b1; cycle(); cycle();
    rst_v = 1'b0; rdy_v = 1'b1; lat = 1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    repeat (8) cycle();
    chk("seq0", iss(0), 32'hBFC0_0000);
    chk("seq1", iss(1), 32'hBFC0_0004);
    chk("seq2", iss(2), 32'hBFC0_0008);
    chk("gap01", gap(0), 32'd2);
    chk("gap12", gap(1), 32'd2);

    rdy_v = 1'b0;
    repeat (10) cycle();
    n0 = issued.size();
    repeat (3) cycle();
    chk("stall_no_req", issued.size() - n0, 32'd0);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    rdy_v = 1'b1; cycle(); rdy_v = 1'b0;
    n0 = issued.size();
    repeat (6) cycle();
    chk("one_refill", issued.size() - n0, 32'd1);
    rdy_v = 1'b1;
    repeat (6) cycle();

    lat = 3;
    wait_req("w39");
    redir_v = 1'b1; pcsrc_v = 2'b01; rpc_v = 32'h0000_0100; imm_v = 32'hFFFF_FFF8;
    n0 = issued.size();
    cycle();
    redir_v = 1'b0;
    #1 chk("flush_after_redirect", {31'd0, instr_valid}, 32'd0);
    repeat (10) cycle();
    chk("redirect_branch", iss(n0), 32'h0000_00F8);

    lat = 1;
    wait_req("w40");
    redir_v = 1'b1; pcsrc_v = 2'b10; alu_v = 32'h0000_2003;
    n0 = issued.size();
    cycle();
    redir_v = 1'b0;
    wait_req("w40b");
    redir_v = 1'b1; pcsrc_v = 2'b00; rpc_v = 32'h1234_5678; alu_v = 32'h0000_9001;
    cycle();
    pcsrc_v = 2'b11;
    cycle();
    redir_v = 1'b0;
    repeat (4) cycle();
    chk("redirect_jalr", iss(n0), 32'h0000_2002);
    chk("redirect_nop", iss(n0 + 1), 32'h0000_2006);

    wait_req("w41");
    redir_v = 1'b1; pcsrc_v = 2'b01; rpc_v = 32'hFFFF_FFF0; imm_v = 32'h0000_000C;
    n0 = issued.size();
    cycle();
    redir_v = 1'b0;
    repeat (6) cycle();
    chk("wrap_hi", iss(n0), 32'hFFFF_FFFC);
    chk("wrap_lo", iss(n0 + 1), 32'h0000_0000);

    lat = 3;
    wait_req("w42");
    rst_v = 1'b1; cycle();
    rst_v = 1'b0; force_rv = 1'b1; cycle();
    force_rv = 1'b0;
    #1 chk("late_rvalid_dropped", {31'd0, instr_valid}, 32'd0);
    n0 = issued.size();
    repeat (4) cycle();
    chk("reset_refetch", iss(n0), RPC);

    repeat (400) begin
      rdy_v   = ($urandom_range(0, 3) != 0);
      redir_v = ($urandom_range(0, 9) == 0);
      pcsrc_v = 2'($urandom_range(0, 3));
      rpc_v   = $urandom;
      imm_v   = $urandom;
      alu_v   = $urandom;
      lat     = $urandom_range(1, 3);
      cycle();
    end
    redir_v = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, address of the first instruction fetched after reset.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-005 Port imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-006 Port imem_rvalid  input  1  instruction-memory response strobe; latency of 1 or more cycles after imem_req.
REQ-007 Port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 Port instr_valid  output  1  buffer head holds a valid instruction.
REQ-009 Port instr  output  32  head instruction word, whose bits [6:0] feed the main decoder op input.
REQ-010 Port instr_pc  output  32  address of the head instruction.
REQ-011 Port instr_ready  input  1  downstream accepts the head instruction this cycle.
REQ-012 Port redirect  input  1  execute stage resolved control flow this cycle.
REQ-013 Port pcsrc  input  2  main decoder encoding: 00 sequential, 01 branch/jal, 10 jalr, 11 reserved.
REQ-014 Port redirect_pc  input  32  PC of the resolving instruction (branch/jal base).
REQ-015 Port immext  input  32  sign-extended immediate.
REQ-016 Port alu_result  input  32  jalr target (rs1+imm).

Function
REQ-017 The block SHALL hold a 32-bit fetch PC, a 2-entry FIFO of {instr, pc} pairs, and a state machine with states IDLE, FETCH and WAIT.
REQ-018 IDLE SHALL go to FETCH on the next cycle; IDLE SHALL be entered only from reset.
REQ-019 FETCH SHALL assert imem_req=1 with imem_addr=PC and go to WAIT only if (FIFO count + 0 outstanding) < 2; otherwise it SHALL hold in FETCH with imem_req=0.
REQ-020 At most one request SHALL be outstanding; imem_req SHALL be 0 in IDLE and WAIT.
REQ-021 In WAIT, imem_rvalid=1 without a pending discard SHALL push {imem_rdata, PC} into the FIFO, set PC to PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and go to FETCH.
REQ-022 imem_rvalid SHALL be ignored in IDLE and FETCH.
REQ-023 instr_valid SHALL equal (FIFO count != 0); instr and instr_pc SHALL show the FIFO head, combinationally from registers.
REQ-024 The head SHALL pop on the edge where instr_valid=1 and instr_ready=1; push and pop in the same cycle SHALL leave the count unchanged.
REQ-025 redirect=1 with pcsrc=01 SHALL set PC to redirect_pc+immext (32-bit truncating add).
REQ-026 redirect=1 with pcsrc=10 SHALL set PC to {alu_result[31:1],1'b0}.
REQ-027 redirect=1 with pcsrc=00 or 11 SHALL have no effect.
REQ-028 An effective redirect SHALL flush the FIFO to empty on the same edge, overriding any pop or push.
REQ-029 If the redirect occurs in WAIT, the block SHALL set a discard flag. The matching imem_rvalid, including one in the same cycle as the redirect, SHALL be dropped and SHALL clear the flag, and the state SHALL go to FETCH with the new PC.
REQ-030 If the redirect occurs in FETCH while imem_req=1, the issued request SHALL likewise be marked discard.
REQ-031 The first request after a redirect SHALL use the redirected PC.
REQ-032 instr_valid SHALL be 0 on the cycle after an effective redirect.
REQ-033 The FIFO SHALL never overflow; a push when full is unreachable, and the verification bench SHALL assert this.

Reset
REQ-034 rst=1 SHALL set PC=RESET_PC, state=IDLE, FIFO count=0, discard=0, imem_req=0 and instr_valid=0 on the next edge.
REQ-035 A reset mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid after reset SHALL be ignored per REQ-022.
REQ-036 instr and instr_pc values SHALL be don't-care while instr_valid=0.

Verification
REQ-037 Reset release, 1-cycle memory, instr_ready=1 -> imem_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008; instr_pc matches each; no gaps beyond the request/response latency.
REQ-038 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered and imem_req stays 0; one accept -> exactly one new request issued.
REQ-039 Response latency 3 cycles, redirect pcsrc=01, redirect_pc=0x100, immext=0xFFFFFFF8 while in WAIT -> stale response dropped; next imem_addr=0xF8; instr_valid=0 until the 0xF8 data returns.
REQ-040 redirect pcsrc=10, alu_result=0x2003 -> next imem_addr=0x2002; redirect with pcsrc=00 -> PC and FIFO unchanged.
REQ-041 PC=0xFFFFFFFC fetch -> next imem_addr=0x00000000.
REQ-042 rst asserted during WAIT, imem_rvalid=1 the cycle after reset -> FIFO stays empty; first request goes to RESET_PC.
